// File: rtl/mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq
// Brief    : Sequential radix-2 shift-add multiplier (MULT/MULTU) with HI/LO
//            result registers; one multiplier bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int                 c_cnt_w    = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 neg_q, neg_d;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [2*WIDTH-1:0]   w_result;

    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    assign w_mag_a  = (is_signed && a[WIDTH-1]) ? -a : a;
    assign w_mag_b  = (is_signed && b[WIDTH-1]) ? -b : b;
    assign w_result = neg_q ? -acc_q : acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, w_mag_a};
                    mplier_d = w_mag_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // WIDTH step cycles, then one cycle that commits the result.
                if (cnt_q == c_cnt_last) begin
                    {hi_d, lo_d} = w_result;
                    state_d      = ST_DONE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + c_cnt_one;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

endmodule
`default_nettype wire
